noc_link_arbiter: RTL
=====================

# noc_link_arbiter

Packet-granular round-robin arbiter sharing one NoC router injection link among `N_PORTS` flit sources, for example several NI instances or NI plus debug/DMA sources. It grants the link to one source at a time, from header flit through tail flit (wormhole lock), so packets never interleave. It also discards malformed packet starts and, optionally, force-releases sources that never send a tail.

## Interface
- `N_PORTS`, 4: number of requesting flit sources (2..8).
- `MAX_FLITS`, 6: maximum flits per packet including header and tail; watchdog limit.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_flit`  in  8*N_PORTS: flit from port i on bits [8i+7:8i].
- `req_valid`  in  N_PORTS: port i presents a valid flit.
- `req_ready`  out  N_PORTS: port i flit accepted this cycle.
- `flit_out`  out  8: flit to router.
- `flit_valid`  out  1: `flit_out` valid.
- `noc_ready`  in  1: router accepts `flit_out` this cycle.
- `busy`  out  1: link locked to a port.
- `grant_id`  out  $clog2(N_PORTS): locked port index; 0 when not busy.
- `hdr_err`  out  1: one-cycle pulse, malformed flit(s) discarded.
- `wdog_err`  out  1: one-cycle pulse, watchdog release (see Configuration).

## Operation
- Header flit: `flit[7:2] == 6'b101111`, dest = `flit[1:0]`. Tail flit: `8'hFF`. Any other flit is a body flit.
- A transfer on the link is `flit_valid && noc_ready`. A transfer on port i is `req_valid[i] && req_ready[i]`.
- State `ARB_IDLE`:
  - `flit_valid=0`, `flit_out=8'h00`, `busy=0`.
  - Candidates are ports with `req_valid` high and a header flit.
  - Winner is the first candidate at or after `rr_ptr`, searching upward modulo `N_PORTS`.
  - On a winner, register `grant_id` and go to `ARB_LOCK`. The header is not consumed in this cycle.
  - Every port with `req_valid` high and a non-header flit gets `req_ready=1` in the same cycle. The flit is discarded and `hdr_err` pulses once, regardless of how many ports are discarded.
  - This discard applies to all such ports whether or not a winner exists.
- State `ARB_LOCK`:
  - `flit_out = req_flit[grant_id]`, `flit_valid = req_valid[grant_id]`.
  - `req_ready[grant_id] = noc_ready`; all other `req_ready` are 0.
  - `busy=1`.
  - `flit_cnt` (3 bits) clears on entry and increments on each link transfer.
  - Releasing the lock: when a tail is transferred, go to `ARB_IDLE` and set `rr_ptr = grant_id+1` (mod `N_PORTS`).
- A header arriving while the link is locked counts only as a flit of the current packet. Headers are not inspected in `ARB_LOCK`.
- `rr_ptr` resets to 0. It changes only on a release.

## Timing
- Reset values: state `ARB_IDLE`, `rr_ptr=0`, `flit_cnt=0`, `grant_id=0`, `busy=0`, `flit_valid=0`, `flit_out=0`, `req_ready=0`, `hdr_err=0`, `wdog_err=0`.
- Reset mid-packet abandons the packet. No tail is generated, and the lock clears at that edge.
- Grant latency: a header present at edge k is granted at edge k+1. The first link transfer is possible in cycle k+1.
- Flit path in `ARB_LOCK` is combinational, with zero added latency. Throughput is one flit per cycle while `noc_ready` is high.
- After every release there is exactly one `ARB_IDLE` cycle before the next grant. The minimum packet period is flits+1 cycles.
- Stalls:
  - `noc_ready=0` holds the current flit. `req_ready` stays 0.
  - `req_valid[grant_id]=0` produces a bubble. The lock is held.
- `hdr_err` and `wdog_err` are registered pulses, asserted in the cycle after the triggering event.

## Configuration
- `NOC_ARB_WATCHDOG_EN` defined:
  - In `ARB_LOCK`, if `flit_cnt` reaches `MAX_FLITS` with no tail transferred, force release next cycle.
  - On that release, set `rr_ptr=grant_id+1`, go to `ARB_IDLE`, and pulse `wdog_err`.
  - Remaining flits of that packet are then seen as non-headers in `ARB_IDLE` and discarded with `hdr_err`.
- Not defined: the lock is held until a tail regardless of length. `wdog_err` is tied to 0 and `flit_cnt` may be removed.

## Test plan
- Single packet: port 0 sends `8'hBD, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF`, with `noc_ready=1` -> `flit_out` carries the same sequence in cycles 1..6, `grant_id=0`, then `busy` drops and `rr_ptr=1`.
- Contention: ports 0, 1 and 3 present headers simultaneously, all 6-flit packets -> grant order 0, 1, 3. No interleaving. One idle cycle between packets.
- Backpressure: during a port 2 packet, `noc_ready` is low for 3 cycles on the 3rd flit -> `flit_out` is stable at that flit, `req_ready[2]=0`, and no flit is lost or duplicated.
- Malformed start: in idle, port 1 presents `8'h55` and port 2 a valid header -> `8'h55` is consumed, `hdr_err` pulses once, and port 2 is granted.
- Reset mid-packet: assert `rst` after the 3rd flit of a port 0 packet -> next cycle all outputs are at reset values. A new header from port 1 is granted normally.
- Watchdog (`NOC_ARB_WATCHDOG_EN`): port 0 sends 7 body flits with no tail -> 6 are forwarded, `wdog_err` pulses, the 7th is discarded with `hdr_err`, and the pending port 1 header is granted.

Source files
------------

// File: rtl/noc_link_arbiter_if.sv
// Handshake bundle between the flit sources, the link arbiter and the router
// injection port. The arbiter binds to the slave modport. The sources and the
// router side (or a bench standing in for them) bind to the master modport.
interface noc_link_arbiter_if #(
    parameter int N_PORTS = 4
);
    localparam int GW = $clog2(N_PORTS);

    // Source side: one 8-bit flit lane per port.
    logic [8*N_PORTS-1:0] req_flit;
    logic [N_PORTS-1:0]   req_valid;
    logic [N_PORTS-1:0]   req_ready;

    // Router side.
    logic [7:0]           flit_out;
    logic                 flit_valid;
    logic                 noc_ready;

    // Status.
    logic                 busy;
    logic [GW-1:0]        grant_id;
    logic                 hdr_err;
    logic                 wdog_err;

    modport master (
        output req_flit, req_valid, noc_ready,
        input  req_ready, flit_out, flit_valid, busy, grant_id, hdr_err, wdog_err
    );

    modport slave (
        input  req_flit, req_valid, noc_ready,
        output req_ready, flit_out, flit_valid, busy, grant_id, hdr_err, wdog_err
    );
endinterface

// File: rtl/noc_link_arbiter.sv
// Packet-granular round-robin arbiter for one NoC injection link.
// A source wins the link with a header flit and keeps it until its tail flit
// is transferred, so packets never interleave. Non-header flits seen while the
// link is idle are malformed packet starts; they are consumed and flagged.
// Optional feature: define NOC_ARB_WATCHDOG_EN to force-release a source that
// has sent MAX_FLITS flits without a tail.
module noc_link_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int MAX_FLITS = 6
) (
    input  logic              clk,
    input  logic              rst,
    noc_link_arbiter_if.slave bus
);
    localparam int         GW        = $clog2(N_PORTS);
    localparam logic [5:0] HDR_TAG   = 6'b101111;
    localparam logic [7:0] TAIL_FLIT = 8'hFF;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [GW-1:0]      grant_q;
    logic [GW-1:0]      rr_ptr_q;
    logic [GW-1:0]      next_rr;
    logic [GW-1:0]      win_id;
    logic               win_found;

    logic [N_PORTS-1:0] cand;
    logic [N_PORTS-1:0] discard;

    logic [7:0]         lock_flit;
    logic               lock_valid;
    logic               link_xfer;
    logic               tail_xfer;
    logic               release_lock;
    logic               wdog_hit;
    logic               hdr_err_q;

    // Classify every valid port flit as a packet start or a stray flit.
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cand    = '0;
        discard = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (bus.req_valid[i]) begin
                if (bus.req_flit[8*i+2 +: 6] == HDR_TAG) begin
                    cand[i] = 1'b1;
                end else begin
                    discard[i] = 1'b1;
                end
            end
        end
    end

    // Round-robin pick: first header candidate at or above rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int off = 0; off < N_PORTS; off++) begin
            idx = (int'(rr_ptr_q) + off) % N_PORTS;
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_id    = GW'(idx);
            end
        end
    end

    // Locked-port flit path and the link events derived from it.
    assign lock_flit    = bus.req_flit[8*int'(grant_q) +: 8];
    assign lock_valid   = bus.req_valid[grant_q];
    assign link_xfer    = (state_q == ARB_LOCK) && !wdog_hit && lock_valid && bus.noc_ready;
    assign tail_xfer    = link_xfer && (lock_flit == TAIL_FLIT);
    assign release_lock = (state_q == ARB_LOCK) && (tail_xfer || wdog_hit);
    assign next_rr      = (grant_q == GW'(N_PORTS - 1)) ? '0 : grant_q + GW'(1);

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: lock on a winning header, unlock on tail or watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_found) begin
                    state_d = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                if (release_lock) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // FSM outputs: idle drains stray flits, lock forwards the granted port.
    always_comb begin
        bus.req_ready  = '0;
        bus.flit_out   = 8'h00;
        bus.flit_valid = 1'b0;
        bus.busy       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                bus.req_ready = discard;
            end
            ARB_LOCK: begin
                bus.busy = 1'b1;
                // A watchdog release cycle keeps the link quiet.
                if (!wdog_hit) begin
                    bus.flit_out           = lock_flit;
                    bus.flit_valid         = lock_valid;
                    bus.req_ready[grant_q] = bus.noc_ready;
                end
            end
            default: ;
        endcase
    end

    // Grant index, round-robin pointer and malformed-start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            hdr_err_q <= 1'b0;
        end else begin
            hdr_err_q <= (state_q == ARB_IDLE) && (|discard);
            if (state_q == ARB_IDLE && win_found) begin
                grant_q <= win_id;
            end else if (release_lock) begin
                grant_q  <= '0;
                rr_ptr_q <= next_rr;
            end
        end
    end

    assign bus.grant_id = grant_q;
    assign bus.hdr_err  = hdr_err_q;

`ifdef NOC_ARB_WATCHDOG_EN
    logic [2:0] flit_cnt_q;
    logic       wdog_err_q;

    assign wdog_hit = (state_q == ARB_LOCK) && (flit_cnt_q == 3'(MAX_FLITS));

    // Count link transfers of the current packet; report a forced release.
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_err_q <= wdog_hit;
            if (state_q != ARB_LOCK) begin
                flit_cnt_q <= '0;
            end else if (link_xfer) begin
                flit_cnt_q <= flit_cnt_q + 3'd1;
            end
        end
    end

    assign bus.wdog_err = wdog_err_q;
`else
    assign wdog_hit     = 1'b0;
    assign bus.wdog_err = 1'b0;
`endif

endmodule
